// File: rtl/float_mult_arbiter.sv
// Round-robin arbiter sharing one stb/ack float multiplier between two requesters.
// Optional build macro ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES with a qNaN error result.
module float_mult_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_stb,
  output logic             req0_ack,
  output logic [31:0]      res0_z,
  output logic             res0_stb,
  input  logic             res0_ack,
  output logic             res0_err,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_stb,
  output logic             req1_ack,
  output logic [31:0]      res1_z,
  output logic             res1_stb,
  input  logic             res1_ack,
  output logic             res1_err,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_a_stb,
  output logic             mul_b_stb,
  input  logic             mul_a_ack,
  input  logic             mul_b_ack,
  input  logic [31:0]      mul_z,
  input  logic             mul_z_stb,
  output logic             mul_z_ack,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DELIVER} state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    owner_q, owner_d;
  logic [31:0]             op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic                    a_done_q, a_done_d, b_done_q, b_done_d;
  logic [1:0]              req_ack_q, req_ack_d;
  logic [1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                    grant;

  logic [1:0]              req_stb_v, res_ack_v;
  logic [1:0][31:0]        req_a_v, req_b_v;

  assign req_stb_v = {req1_stb, req0_stb};
  assign res_ack_v = {res1_ack, res0_ack};
  assign req_a_v   = {req1_a, req0_a};
  assign req_b_v   = {req1_b, req0_b};

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    a_done_d  = a_done_q;
    b_done_d  = b_done_q;
    req_ack_d = '0;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    mul_z_ack = 1'b0;
`ifdef ARB_TIMEOUT_EN
    err_d     = err_q;
    tmo_d     = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_stb_v) begin
          // Contention resolved by the rr pointer; a lone request wins outright.
          grant            = (&req_stb_v) ? rr_q : req_stb_v[1];
          owner_d          = grant;
          op_a_d           = req_a_v[grant];
          op_b_d           = req_b_v[grant];
          req_ack_d[grant] = 1'b1;
          a_done_d         = 1'b0;
          b_done_d         = 1'b0;
          state_d          = S_SEND;
        end
      end
      S_SEND: begin
        if (mul_a_stb && mul_a_ack) a_done_d = 1'b1;
        if (mul_b_stb && mul_b_ack) b_done_d = 1'b1;
        if (a_done_d && b_done_d)   state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (mul_z_stb) begin
          res_d     = mul_z;
          mul_z_ack = 1'b1;
          state_d   = S_DELIVER;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          res_d   = 32'h7FC0_0000;
          err_d   = 1'b1;
          state_d = S_DELIVER;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      S_DELIVER: begin
        if (res_ack_v[owner_q]) begin
          cnt_d[owner_q] = cnt_q[owner_q] + CNT_W'(1);
          rr_d           = ~owner_q;
          state_d        = S_IDLE;
`ifdef ARB_TIMEOUT_EN
          err_d          = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      req_ack_q <= '0;
      cnt_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q     <= 1'b0;
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q     <= res_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      req_ack_q <= req_ack_d;
      cnt_q     <= cnt_d;
`ifdef ARB_TIMEOUT_EN
      err_q     <= err_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Each operand strobe falls independently once its own transfer has completed.
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign mul_a_stb = (state_q == S_SEND) && !a_done_q;
  assign mul_b_stb = (state_q == S_SEND) && !b_done_q;

  assign req0_ack  = req_ack_q[0];
  assign req1_ack  = req_ack_q[1];
  assign res0_stb  = (state_q == S_DELIVER) && !owner_q;
  assign res1_stb  = (state_q == S_DELIVER) &&  owner_q;
  assign res0_z    = owner_q ? 32'h0 : res_q;
  assign res1_z    = owner_q ? res_q : 32'h0;
  assign done_cnt0 = cnt_q[0];
  assign done_cnt1 = cnt_q[1];

`ifdef ARB_TIMEOUT_EN
  assign res0_err  = res0_stb && err_q;
  assign res1_err  = res1_stb && err_q;
`else
  assign res0_err  = 1'b0;
  assign res1_err  = 1'b0;
`endif

endmodule

// File: tb/tb_float_mult_arbiter.sv
// Directed bench for float_mult_arbiter with a behavioural stb/ack multiplier model.
module tb_float_mult_arbiter;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_stb = 1'b0, req1_stb = 1'b0;
  logic        res0_ack = 1'b1, res1_ack = 1'b1;
  logic        req0_ack, req1_ack, res0_stb, res1_stb, res0_err, res1_err;
  logic [31:0] res0_z, res1_z, mul_a, mul_b;
  logic        mul_a_stb, mul_b_stb, mul_z_ack;
  logic        mul_a_ack = 1'b0, mul_b_ack = 1'b0, mul_z_stb = 1'b0;
  logic [31:0] mul_z = '0;
  logic [CW-1:0] done_cnt0, done_cnt1;

  float_mult_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_a(req0_a), .req0_b(req0_b), .req0_stb(req0_stb), .req0_ack(req0_ack),
    .res0_z(res0_z), .res0_stb(res0_stb), .res0_ack(res0_ack), .res0_err(res0_err),
    .req1_a(req1_a), .req1_b(req1_b), .req1_stb(req1_stb), .req1_ack(req1_ack),
    .res1_z(res1_z), .res1_stb(res1_stb), .res1_ack(res1_ack), .res1_err(res1_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack), .mul_z(mul_z), .mul_z_stb(mul_z_stb),
    .mul_z_ack(mul_z_ack), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Known products; 1.0*x passes x through.
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000) return b;
    case ({a, b})
      {32'h3F99999A, 32'h40866666}: return 32'h40A147AE;
      {32'h4089999A, 32'hC0933333}: return 32'hC19E3D71;
      {32'h40000000, 32'h40400000}: return 32'h40C00000;
      {32'hBF800000, 32'h40000000}: return 32'hC0000000;
      default:                      return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Posedge monitor: handshakes, grants, delivered results, protocol violations.
  int ack0n = 0, ack1n = 0, both_res = 0, zack_bad = 0, err_seen = 0;
  int grants[$];
  logic [31:0] r0q[$], r1q[$];
  logic a_hs_q = 1'b0, b_hs_q = 1'b0, z_hs_q = 1'b0;
  bit rec = 1'b0;
  logic sa[$], sb[$], ah[$], bh[$], sr[$];

  always @(posedge clk) begin
    a_hs_q <= mul_a_stb && mul_a_ack;
    b_hs_q <= mul_b_stb && mul_b_ack;
    z_hs_q <= mul_z_stb && mul_z_ack;
    if (req0_ack) begin ack0n <= ack0n + 1; grants.push_back(0); end
    if (req1_ack) begin ack1n <= ack1n + 1; grants.push_back(1); end
    if (res0_stb && res0_ack) r0q.push_back(res0_z);
    if (res1_stb && res1_ack) r1q.push_back(res1_z);
    if (res0_stb && res1_stb) both_res <= both_res + 1;
    if (mul_z_ack && !mul_z_stb) zack_bad <= zack_bad + 1;
    if (res0_err || res1_err) err_seen <= err_seen + 1;
    if (rec) begin
      sa.push_back(mul_a_stb); sb.push_back(mul_b_stb);
      ah.push_back(mul_a_stb && mul_a_ack); bh.push_back(mul_b_stb && mul_b_ack);
      sr.push_back(res0_stb);
    end
  end

  // Requesters: hold stb until the target number of grants is reached.
  int pend0 = 0, pend1 = 0;
  initial forever begin
    @(negedge clk);
    req0_stb = (pend0 > ack0n);
    req1_stb = (pend1 > ack1n);
  end

  // Multiplier model with per-operand ack delays and result latency.
  int a_dly = 0, b_dly = 0, z_dly = 2, ac = 0, bc = 0, zc = 0;
  bit z_en = 1'b1, have_a = 1'b0, have_b = 1'b0;
  logic [31:0] cap_a = '0, cap_b = '0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0;
      have_a = 0; have_b = 0; ac = 0; bc = 0; zc = 0;
    end else begin
      if (mul_a_ack) begin mul_a_ack = 0; if (a_hs_q) have_a = 1; end
      else if (mul_a_stb && !have_a) begin
        if (ac >= a_dly) begin mul_a_ack = 1; cap_a = mul_a; ac = 0; end else ac++;
      end
      if (mul_b_ack) begin mul_b_ack = 0; if (b_hs_q) have_b = 1; end
      else if (mul_b_stb && !have_b) begin
        if (bc >= b_dly) begin mul_b_ack = 1; cap_b = mul_b; bc = 0; end else bc++;
      end
      if (mul_z_stb) begin
        if (z_hs_q) begin mul_z_stb = 0; have_a = 0; have_b = 0; end
      end else if (have_a && have_b && z_en) begin
        if (zc >= z_dly) begin mul_z = prod(cap_a, cap_b); mul_z_stb = 1; zc = 0; end else zc++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pend0 = ack0n; pend1 = ack1n;
    repeat (2) @(negedge clk);
    r0q.delete(); r1q.delete(); grants.delete();
    rst = 1'b0;
  endtask

  task automatic wait_res(input int n0, input int n1, input string nm);
    int t = 0;
    while ((r0q.size() < n0 || r1q.size() < n1) && t < 400) begin @(negedge clk); t++; end
    @(negedge clk);
    checks++;
    if (t >= 400) begin
      errors++;
      $display("FAIL %s: results %0d/%0d expected %0d/%0d", nm, r0q.size(), r1q.size(), n0, n1);
    end
  endtask

  typedef struct {
    bit          k;
    logic [31:0] a, b, z;
    int          ad, bd, zd;
  } vec_t;
  vec_t vt[5];

  initial begin
    int e0, e1, n0, n1, t, bad, ia, ib, a1s;
    logic [31:0] zs, g;
    vt[0] = '{1'b0, 32'h3F99999A, 32'h40866666, 32'h40A147AE, 0, 0, 2};
    vt[1] = '{1'b1, 32'h4089999A, 32'hC0933333, 32'hC19E3D71, 1, 2, 0};
    vt[2] = '{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 2, 0, 5};
    vt[3] = '{1'b1, 32'hBF800000, 32'h40000000, 32'hC0000000, 0, 0, 1};
    vt[4] = '{1'b0, 32'h3F800000, 32'h12345678, 32'h12345678, 4, 4, 3};

    repeat (3) @(negedge clk);
    chk("rst_ctrl", {23'h0, req0_ack, req1_ack, res0_stb, res1_stb, res0_err, res1_err,
                     mul_a_stb, mul_b_stb, mul_z_ack}, 32'h0);
    chk("rst_data", mul_a | mul_b | res0_z | res1_z, 32'h0);
    chk("rst_cnt", {28'h0, done_cnt0, done_cnt1}, 32'h0);
    rst = 1'b0;

    // Single requests from a table of operands and handshake timings.
    e0 = 0; e1 = 0;
    for (int i = 0; i < 5; i++) begin
      a_dly = vt[i].ad; b_dly = vt[i].bd; z_dly = vt[i].zd;
      n0 = r0q.size(); n1 = r1q.size(); a1s = ack0n + ack1n;
      if (vt[i].k) begin req1_a = vt[i].a; req1_b = vt[i].b; pend1++; e1++; end
      else         begin req0_a = vt[i].a; req0_b = vt[i].b; pend0++; e0++; end
      wait_res(n0 + (vt[i].k ? 0 : 1), n1 + (vt[i].k ? 1 : 0), $sformatf("vec%0d_done", i));
      chk($sformatf("vec%0d_z", i), vt[i].k ? r1q[$] : r0q[$], vt[i].z);
      chk($sformatf("vec%0d_mul_a", i), cap_a, vt[i].a);
      chk($sformatf("vec%0d_mul_b", i), cap_b, vt[i].b);
      chk($sformatf("vec%0d_other", i), vt[i].k ? r0q.size() : r1q.size(), vt[i].k ? n0 : n1);
      chk($sformatf("vec%0d_acks", i), ack0n + ack1n - a1s, 1);
      chk($sformatf("vec%0d_cnt", i), {28'h0, done_cnt0, done_cnt1}, {28'h0, CW'(e0), CW'(e1)});
    end

    // Simultaneous requests out of reset: requester 0 first.
    a_dly = 0; b_dly = 0; z_dly = 1;
    do_reset();
    req0_a = 32'h3F99999A; req0_b = 32'h40866666;
    req1_a = 32'h4089999A; req1_b = 32'hC0933333;
    pend0++; pend1++;
    wait_res(1, 1, "sim_done");
    chk("sim_order", {30'h0, grants.size() > 0 ? grants[0][0] : 1'bx,
                      grants.size() > 1 ? grants[1][0] : 1'bx}, 32'h1);
    chk("sim_z0", r0q[0], 32'h40A147AE);
    chk("sim_z1", r1q[0], 32'hC19E3D71);
    chk("sim_cnt", {28'h0, done_cnt0, done_cnt1}, 32'h5);

    // Continuous contention alternates; a fourth op each wraps the 2-bit counters.
    do_reset();
    pend0 += 3; pend1 += 3;
    wait_res(3, 3, "cont_done");
    g = '0;
    for (int i = 0; i < 6; i++) g[i] = (i < grants.size()) ? grants[i][0] : 1'bx;
    chk("cont_alt", g, 32'h2A);
    chk("cont_cnt", {28'h0, done_cnt0, done_cnt1}, 32'hF);
    pend0++; pend1++;
    wait_res(4, 4, "wrap_done");
    chk("wrap_cnt", {28'h0, done_cnt0, done_cnt1}, 32'h0);

    // Staggered operand acks: b first, a three cycles later.
    a_dly = 3; b_dly = 0; z_dly = 1;
    rec = 1'b1;
    pend0++;
    wait_res(5, 4, "stag_done");
    rec = 1'b0;
    ia = -1; ib = -1; bad = 0;
    for (int i = 0; i < ah.size(); i++) begin
      if (ah[i]) begin if (ia < 0) ia = i; else bad++; end
      if (bh[i]) begin if (ib < 0) ib = i; else bad++; end
    end
    chk("stag_single_hs", bad, 0);
    chk("stag_gap", ia - ib, 3);
    chk("stag_b_drop", (ib >= 0 && ib + 1 < sb.size()) ? {31'h0, sb[ib+1]} : 32'hX, 0);
    chk("stag_a_held", (ib >= 0 && ib + 1 < sa.size()) ? {31'h0, sa[ib+1]} : 32'hX, 1);
    chk("stag_a_drop", (ia >= 0 && ia + 1 < sa.size()) ? {31'h0, sa[ia+1]} : 32'hX, 0);
    chk("stag_z", r0q[$], 32'h40A147AE);

    // Slow consumer holds result; pending req1 must not be granted meanwhile.
    a_dly = 0; b_dly = 0; z_dly = 2;
    res0_ack = 1'b0;
    req0_a = 32'h40000000; req0_b = 32'h40400000;
    pend0++;
    t = 0;
    while (res0_stb !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("dly_reached", t < 100, 1);
    pend1++;
    zs = res0_z; a1s = ack1n; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res0_stb !== 1'b1 || res0_z !== zs || res1_stb !== 1'b0) bad++;
    end
    chk("dly_hold", bad, 0);
    chk("dly_z", zs, 32'h40C00000);
    chk("dly_no_grant", ack1n - a1s, 0);
    res0_ack = 1'b1;
    wait_res(6, 5, "dly_done");
    chk("dly_z1", r1q[$], 32'hC19E3D71);
    chk("dly_cnt", {28'h0, done_cnt0, done_cnt1}, {28'h0, 2'd2, 2'd1});

    // Reset while waiting on the multiplier clears everything at once.
    z_en = 1'b0;
    pend0++;
    t = 0;
    while (!(have_a && have_b) && t < 100) begin @(negedge clk); t++; end
    chk("rw_reached", t < 100, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rw_ctrl", {23'h0, req0_ack, req1_ack, res0_stb, res1_stb, res0_err, res1_err,
                    mul_a_stb, mul_b_stb, mul_z_ack}, 32'h0);
    chk("rw_data", mul_a | mul_b | res0_z | res1_z, 32'h0);
    chk("rw_cnt", {28'h0, done_cnt0, done_cnt1}, 32'h0);
    pend0 = ack0n; pend1 = ack1n;
    repeat (2) @(negedge clk);
    r0q.delete(); r1q.delete(); grants.delete();
    rst = 1'b0;

`ifdef ARB_TIMEOUT_EN
    // No result ever arrives: 16 WAIT cycles then qNaN with err.
    sa.delete(); sb.delete(); ah.delete(); bh.delete(); sr.delete();
    res0_ack = 1'b0;
    rec = 1'b1;
    pend0++;
    t = 0;
    while (res0_stb !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    rec = 1'b0;
    chk("tmo_reached", t < 100, 1);
    chk("tmo_z", res0_z, 32'h7FC00000);
    chk("tmo_err", res0_err, 1);
    ia = -1; ib = -1;
    for (int i = 0; i < sr.size(); i++) begin
      if ((ah[i] || bh[i])) ia = i;
      if (sr[i] && ib < 0) ib = i;
    end
    chk("tmo_len", ib - ia, 17);
    res0_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("tmo_err_clr", {30'h0, res0_stb, res0_err}, 32'h0);
    do_reset();
`else
    chk("no_err", err_seen, 0);
`endif
    z_en = 1'b1;

    chk("both_res_stb", both_res, 0);
    chk("zack_outside", zack_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
